// File: rtl/uart_pkg.sv
// Shared encodings for the configurable UART transmitter: FSM states, parity and baud codes,
// and the mapping from the dataBits field to a bit count and data mask.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  localparam logic [1:0] BAUD_1200 = 2'd0;
  localparam logic [1:0] BAUD_2400 = 2'd1;
  localparam logic [1:0] BAUD_4800 = 2'd2;
  localparam logic [1:0] BAUD_9600 = 2'd3;

  function automatic logic [3:0] dataBitsCount(input logic [1:0] sel);
    return 4'd5 + {2'b00, sel};
  endfunction

  // Masking the latched word means unsent upper bits can never leak into the line or parity.
  function automatic logic [7:0] dataMask(input logic [1:0] sel);
    logic [7:0] mask;
    unique case (sel)
      2'd0:    mask = 8'h1F;
      2'd1:    mask = 8'h3F;
      2'd2:    mask = 8'h7F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Valid/ready byte handshake between the core's I/O write path and the UART input FIFO.
interface uart_tx_cfg_if;
  logic [7:0] dataInput;
  logic       inValid;
  logic       inReady;

  modport master (output dataInput, output inValid, input inReady);
  modport slave  (input dataInput, input inValid, output inReady);
endinterface

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO feeding the transmitter; power-of-two depth so pointers wrap for free.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clkTx,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             doPush, doPop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rdPtr_q];

  always_comb begin
    doPush  = push_i & ~full_o;
    doPop   = pop_i & ~empty_o;
    wrPtr_d = doPush ? wrPtr_q + AW'(1) : wrPtr_q;
    rdPtr_d = doPop ? rdPtr_q + AW'(1) : rdPtr_q;
    count_d = count_q;
    unique case ({doPush, doPop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clkTx) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clkTx) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with run-time frame format and baud select; the format is captured per frame
// at FIFO pop, and all line-side outputs are registered one cycle behind the FSM state.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_1200   = 41667,
  parameter int DIV_2400   = 20833,
  parameter int DIV_4800   = 10417,
  parameter int DIV_9600   = 5208,
  parameter int CNT_W      = 16
) (
  input  logic                          clkTx,
  input  logic                          reset,
  uart_tx_cfg_if.slave                  inBus,
  input  logic [1:0]                    baudRate,
  input  logic [1:0]                    dataBits,
  input  logic [1:0]                    parityMode,
  input  logic                          stopBits,
  output logic                          serialOut,
  output logic                          busy,
  output logic                          txDone,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

  localparam logic [CNT_W-1:0] DIV0 = CNT_W'(DIV_1200);
  localparam logic [CNT_W-1:0] DIV1 = CNT_W'(DIV_2400);
  localparam logic [CNT_W-1:0] DIV2 = CNT_W'(DIV_4800);
  localparam logic [CNT_W-1:0] DIV3 = CNT_W'(DIV_9600);

  function automatic logic [CNT_W-1:0] divFor(input logic [1:0] sel);
    logic [CNT_W-1:0] d;
    unique case (sel)
      BAUD_1200: d = DIV0;
      BAUD_2400: d = DIV1;
      BAUD_4800: d = DIV2;
      default:   d = DIV3;
    endcase
    return d;
  endfunction

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             stop2_q, stop2_d;
  logic [7:0]       word_q;
  logic [CNT_W-1:0] div_q;
  logic [3:0]       nbits_q;
  logic             parEn_q, parOdd_q, twoStop_q;
  logic             serialOut_q, busy_q, txDone_q;

  logic             popReq, lineBit, frameEnd;
  logic             bitEnd, lastBit, parBit;
  logic [CNT_W-1:0] cntInc;
  logic [7:0]       fifoData;
  logic             fifoFull, fifoEmpty;
  logic             push;

  assign inBus.inReady = ~fifoFull & ~reset;
  assign push          = inBus.inValid & inBus.inReady;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clkTx   (clkTx),
    .reset   (reset),
    .push_i  (push),
    .data_i  (inBus.dataInput),
    .pop_i   (popReq),
    .data_o  (fifoData),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  assign bitEnd  = (cnt_q == div_q - CNT_W'(1));
  assign cntInc  = cnt_q + CNT_W'(1);
  assign lastBit = ({1'b0, idx_q} == nbits_q - 4'd1);
  assign parBit  = (^word_q) ^ parOdd_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    stop2_d  = stop2_q;
    popReq   = 1'b0;
    lineBit  = 1'b1;
    frameEnd = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifoEmpty) begin
          popReq  = 1'b1;
          state_d = ST_START;
          cnt_d   = '0;
          idx_d   = '0;
          stop2_d = 1'b0;
        end
      end
      ST_START: begin
        lineBit = 1'b0;
        if (bitEnd) begin
          cnt_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cntInc;
        end
      end
      ST_DATA: begin
        lineBit = word_q[idx_q];
        if (bitEnd) begin
          cnt_d = '0;
          if (lastBit) state_d = parEn_q ? ST_PARITY : ST_STOP;
          else         idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cntInc;
        end
      end
      ST_PARITY: begin
        lineBit = parBit;
        if (bitEnd) begin
          cnt_d   = '0;
          state_d = ST_STOP;
        end else begin
          cnt_d = cntInc;
        end
      end
      ST_STOP: begin
        lineBit = 1'b1;
        if (bitEnd) begin
          cnt_d = '0;
          if (twoStop_q && !stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            // Popping straight from STOP keeps queued frames back-to-back with no idle cycle.
            frameEnd = 1'b1;
            stop2_d  = 1'b0;
            idx_d    = '0;
            if (!fifoEmpty) begin
              popReq  = 1'b1;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end else begin
          cnt_d = cntInc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkTx) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      stop2_q     <= 1'b0;
      word_q      <= '0;
      div_q       <= DIV3;
      nbits_q     <= 4'd8;
      parEn_q     <= 1'b0;
      parOdd_q    <= 1'b0;
      twoStop_q   <= 1'b0;
      serialOut_q <= 1'b1;
      busy_q      <= 1'b0;
      txDone_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stop2_q     <= stop2_d;
      serialOut_q <= lineBit;
      busy_q      <= (state_q != ST_IDLE);
      txDone_q    <= frameEnd;
      if (popReq) begin
        word_q    <= fifoData & dataMask(dataBits);
        div_q     <= divFor(baudRate);
        nbits_q   <= dataBitsCount(dataBits);
        parEn_q   <= (parityMode == PAR_EVEN) || (parityMode == PAR_ODD);
        parOdd_q  <= (parityMode == PAR_ODD);
        twoStop_q <= stopBits;
      end
    end
  end

  assign serialOut = serialOut_q;
  assign busy      = busy_q;
  assign txDone    = txDone_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: a line monitor decodes every frame against a scoreboard
// queue of expected level sequences filled when words are pushed.
module tb_uart_tx_cfg;

  typedef struct {
    logic [11:0] levels;
    int          nLevels;
    int          div;
    int          maxGap;
  } exp_t;

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  baud;
    logic [1:0]  bits;
    logic [1:0]  par;
    logic        stop;
    logic [11:0] levels;
    int          nLevels;
    int          div;
  } vec_t;

  logic       clkTx;
  logic       reset;
  logic [1:0] baudRate;
  logic [1:0] dataBits;
  logic [1:0] parityMode;
  logic       stopBits;
  logic       serialOut;
  logic       busy;
  logic       txDone;
  logic [2:0] fifoCount;

  int   checks;
  int   passes;
  int   framesDone;
  int   gap;
  bit   monEn;
  exp_t expQ[$];
  vec_t vecs[4];

  uart_tx_cfg_if bus ();

  uart_tx_cfg #(
    .FIFO_DEPTH (4),
    .DIV_1200   (16),
    .DIV_2400   (8),
    .DIV_4800   (6),
    .DIV_9600   (4),
    .CNT_W      (16)
  ) dut (
    .clkTx      (clkTx),
    .reset      (reset),
    .inBus      (bus),
    .baudRate   (baudRate),
    .dataBits   (dataBits),
    .parityMode (parityMode),
    .stopBits   (stopBits),
    .serialOut  (serialOut),
    .busy       (busy),
    .txDone     (txDone),
    .fifoCount  (fifoCount)
  );

  initial clkTx = 1'b0;
  always #5 clkTx = ~clkTx;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  task automatic checkAtMost(input string name, input int act, input int limit);
    checks++;
    if (act <= limit) passes++;
    else $display("[TB] FAIL %s: got %0d expected at most %0d", name, act, limit);
  endtask

  function automatic exp_t frame8N1(input logic [7:0] d, input int div, input int maxGap);
    exp_t e;
    e.levels  = {2'b00, 1'b1, d, 1'b0};
    e.nLevels = 10;
    e.div     = div;
    e.maxGap  = maxGap;
    return e;
  endfunction

  function automatic exp_t frame5N1(input logic [7:0] d, input int div, input int maxGap);
    exp_t e;
    e.levels  = {5'b00000, 1'b1, d[4:0], 1'b0};
    e.nLevels = 7;
    e.div     = div;
    e.maxGap  = maxGap;
    return e;
  endfunction

  // Called at a negedge; pushes one word once inReady allows and optionally scoreboards it.
  task automatic applyStimulus(input logic [7:0] d, input bit track, input exp_t e);
    int waitCyc = 0;
    while (bus.inReady !== 1'b1 && waitCyc < 500) begin
      @(negedge clkTx);
      waitCyc++;
    end
    checkAtMost("pushReadyWait", waitCyc, 499);
    bus.dataInput = d;
    bus.inValid   = 1'b1;
    if (track) expQ.push_back(e);
    @(negedge clkTx);
    bus.inValid   = 1'b0;
    bus.dataInput = 8'($urandom_range(0, 255));
  endtask

  task automatic setCfg(input logic [1:0] b, input logic [1:0] n, input logic [1:0] p, input logic s);
    baudRate   = b;
    dataBits   = n;
    parityMode = p;
    stopBits   = s;
  endtask

  task automatic waitFrames(input int target);
    int n = 0;
    while (framesDone < target && n < 3000) begin
      @(negedge clkTx);
      n++;
    end
    checkOutput("frameCount", framesDone, target);
  endtask

  initial begin : monitor
    exp_t e;
    int   frameLen, glitches, donePulses, donePos, busyLow;
    gap = 0;
    forever begin
      @(negedge clkTx);
      if (monEn && serialOut === 1'b0) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedFrame", 1, 0);
        end else begin
          e = expQ.pop_front();
          if (e.maxGap >= 0) checkAtMost("interFrameGap", gap, e.maxGap);
          frameLen   = e.nLevels * e.div;
          glitches   = 0;
          donePulses = 0;
          donePos    = -1;
          busyLow    = 0;
          for (int c = 0; c < frameLen; c++) begin
            if (c > 0) @(negedge clkTx);
            if (serialOut !== e.levels[c / e.div]) glitches++;
            if (c % e.div == e.div / 2)
              checkOutput($sformatf("lineLevel%0d", c / e.div), {31'd0, serialOut},
                          {31'd0, e.levels[c / e.div]});
            if (busy !== 1'b1) busyLow++;
            if (txDone === 1'b1) begin
              donePulses++;
              donePos = c;
            end
          end
          checkOutput("lineGlitchCycles", glitches, 0);
          checkOutput("busyLowInFrame", busyLow, 0);
          checkOutput("txDonePulses", donePulses, 1);
          checkOutput("txDoneCycle", donePos, frameLen - 1);
          framesDone++;
        end
        gap = 0;
      end else begin
        gap++;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    exp_t e;
    exp_t none;
    int   base, lat, lowSeen, waitCyc;

    checks = 0;
    passes = 0;
    framesDone = 0;
    monEn = 1'b0;
    none = frame8N1(8'h00, 4, -1);

    vecs[0] = '{data: 8'hA5, baud: 2'd3, bits: 2'd3, par: 2'd0, stop: 1'b0,
                levels: 12'h34A, nLevels: 10, div: 4};
    vecs[1] = '{data: 8'h83, baud: 2'd1, bits: 2'd2, par: 2'd1, stop: 1'b1,
                levels: 12'h606, nLevels: 11, div: 8};
    vecs[2] = '{data: 8'h1F, baud: 2'd0, bits: 2'd0, par: 2'd2, stop: 1'b0,
                levels: 12'h0BE, nLevels: 8, div: 16};
    vecs[3] = '{data: 8'h2D, baud: 2'd2, bits: 2'd1, par: 2'd1, stop: 1'b0,
                levels: 12'h15A, nLevels: 9, div: 6};

    reset = 1'b1;
    bus.inValid = 1'b0;
    bus.dataInput = 8'h00;
    setCfg(2'd3, 2'd3, 2'd0, 1'b0);

    repeat (2) @(negedge clkTx);
    checkOutput("inReadyDuringReset", {31'd0, bus.inReady}, 0);
    checkOutput("resetSerialOut", {31'd0, serialOut}, 1);
    checkOutput("resetBusy", {31'd0, busy}, 0);
    checkOutput("resetTxDone", {31'd0, txDone}, 0);
    checkOutput("resetFifoCount", {29'd0, fifoCount}, 0);
    reset = 1'b0;
    @(negedge clkTx);
    checkOutput("inReadyAfterReset", {31'd0, bus.inReady}, 1);
    monEn = 1'b1;

    for (int i = 0; i < 4; i++) begin
      setCfg(vecs[i].baud, vecs[i].bits, vecs[i].par, vecs[i].stop);
      e.levels  = vecs[i].levels;
      e.nLevels = vecs[i].nLevels;
      e.div     = vecs[i].div;
      e.maxGap  = -1;
      base = framesDone;
      applyStimulus(vecs[i].data, 1'b1, e);
      waitFrames(base + 1);
      repeat (3) @(negedge clkTx);
    end

    // Burst of five words into a four-deep FIFO while idle.
    setCfg(2'd3, 2'd3, 2'd0, 1'b0);
    base = framesDone;
    applyStimulus(8'h00, 1'b1, frame8N1(8'h00, 4, -1));
    applyStimulus(8'hFF, 1'b1, frame8N1(8'hFF, 4, 4));
    applyStimulus(8'h3C, 1'b1, frame8N1(8'h3C, 4, 4));
    applyStimulus(8'h81, 1'b1, frame8N1(8'h81, 4, 4));
    applyStimulus(8'h55, 1'b1, frame8N1(8'h55, 4, 4));
    checkOutput("burstInReadyFull", {31'd0, bus.inReady}, 0);
    checkOutput("burstFifoCountFull", {29'd0, fifoCount}, 4);
    waitFrames(base + 1);
    checkOutput("burstFifoCountAfterPop", {29'd0, fifoCount}, 3);
    checkOutput("burstInReadyAfterPop", {31'd0, bus.inReady}, 1);
    waitFrames(base + 5);
    repeat (3) @(negedge clkTx);

    // Config changed mid-frame must only take effect on the next popped word.
    base = framesDone;
    setCfg(2'd3, 2'd3, 2'd0, 1'b0);
    applyStimulus(8'h5A, 1'b1, frame8N1(8'h5A, 4, -1));
    repeat (5) @(negedge clkTx);
    setCfg(2'd2, 2'd0, 2'd0, 1'b0);
    applyStimulus(8'hE6, 1'b1, frame5N1(8'hE6, 6, 4));
    waitFrames(base + 2);
    repeat (3) @(negedge clkTx);

    // Reset during DATA bit 3 with a second word still queued.
    monEn = 1'b0;
    setCfg(2'd3, 2'd3, 2'd0, 1'b0);
    applyStimulus(8'hF7, 1'b0, none);
    applyStimulus(8'h12, 1'b0, none);
    waitCyc = 0;
    while (serialOut !== 1'b0 && waitCyc < 20) begin
      @(negedge clkTx);
      waitCyc++;
    end
    checkAtMost("resetTestStartWait", waitCyc, 19);
    repeat (17) @(negedge clkTx);
    checkOutput("preResetBit3", {31'd0, serialOut}, 0);
    checkOutput("preResetFifoCount", {29'd0, fifoCount}, 1);
    reset = 1'b1;
    @(negedge clkTx);
    checkOutput("midResetSerialOut", {31'd0, serialOut}, 1);
    checkOutput("midResetBusy", {31'd0, busy}, 0);
    checkOutput("midResetFifoCount", {29'd0, fifoCount}, 0);
    checkOutput("midResetInReady", {31'd0, bus.inReady}, 0);
    reset = 1'b0;
    @(negedge clkTx);
    checkOutput("postResetInReady", {31'd0, bus.inReady}, 1);
    lowSeen = 0;
    repeat (12) begin
      @(negedge clkTx);
      if (serialOut !== 1'b1 || busy !== 1'b0) lowSeen++;
    end
    checkOutput("postResetIdleLine", lowSeen, 0);

    // Fresh push after reset: serialOut must fall two edges after the push edge.
    monEn = 1'b1;
    base = framesDone;
    bus.dataInput = 8'h3C;
    bus.inValid = 1'b1;
    expQ.push_back(frame8N1(8'h3C, 4, -1));
    @(negedge clkTx);
    bus.inValid = 1'b0;
    lat = 1;
    while (serialOut !== 1'b0 && lat < 20) begin
      @(negedge clkTx);
      lat++;
    end
    checkOutput("pushToStartLatency", lat, 3);
    waitFrames(base + 1);
    repeat (5) @(negedge clkTx);
    checkOutput("scoreboardEmpty", expQ.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
- Parametrised successor UART transmitter.
- Serialises bytes with run-time frame format: 5-8 data bits, none/even/odd parity, 1 or 2 stop bits.
- Baud rate selectable from four parameterised divisors.
- Small input FIFO behind a valid/ready handshake, so the pipeline side can queue words without waiting per frame.
- Sits between the core's I/O write path and the serial pin.

Parameters:
- FIFO_DEPTH, 4, input FIFO entries (power of two, ≥2).
- DIV_1200, 41667, clocks per bit when baudRate=0.
- DIV_2400, 20833, clocks per bit when baudRate=1.
- DIV_4800, 10417, clocks per bit when baudRate=2.
- DIV_9600, 5208, clocks per bit when baudRate=3.
- CNT_W, 16, bit-counter width; every DIV_* must be ≥2 and fit in it.

Ports:
- clkTx  in  1  transmit clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- dataInput  in  8  word to send; LSB first.
- inValid  in  1  dataInput valid.
- inReady  out  1  FIFO can accept; a push happens when inValid & inReady.
- baudRate  in  2  divisor select.
- dataBits  in  2  0..3 → 5..8 data bits.
- parityMode  in  2  0 none, 1 even, 2 odd, 3 treated as none.
- stopBits  in  1  0 → one stop bit, 1 → two.
- serialOut  out  1  serial line; idles high.
- busy  out  1  frame in progress.
- txDone  out  1  one-cycle pulse at frame end.
- fifoCount  out  $clog2(FIFO_DEPTH)+1  occupied entries.

Behaviour:
- Reset:
  - Sampled on a clkTx edge.
  - On the following cycle: serialOut=1, busy=0, txDone=0, fifoCount=0, state IDLE.
  - inReady=0 while reset is high; inReady=1 the first cycle after.
  - Reset mid-frame aborts the frame; the line returns high the next cycle; FIFO contents are discarded.
- Handshake:
  - inReady = !full & !reset.
  - A push while full cannot occur.
  - Push and pop in the same cycle leaves fifoCount unchanged.
  - dataInput is ignored when no push occurs.
- States: IDLE, START, DATA, PARITY, STOP. Encodings live in the package.
- IDLE:
  - serialOut=1, busy=0.
  - If FIFO is non-empty: pop the head, latch word plus baudRate/dataBits/parityMode/stopBits into shadow registers, clear counters, go to START.
  - Config changes mid-frame have no effect until the next pop.
- Latency: a word pushed at edge N into an empty FIFO is popped at edge N+1; serialOut falls at edge N+2.
- Every bit period is exactly DIV cycles of the latched divisor. The bit counter runs 0..DIV-1, then advances.
- START drives 0, then DATA.
- DATA:
  - Drives bit[idx], with idx running 0..nbits-1.
  - Bits above nbits are never sent.
  - After the last bit, go to PARITY if parity is enabled, else STOP.
- PARITY: drives the XOR of the sent bits for even, its inverse for odd.
- STOP:
  - Drives 1 for DIV cycles, or 2·DIV cycles when stopBits=1.
  - At the end, assert txDone for one cycle.
  - If the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
- busy=1 in every non-IDLE state, including the back-to-back transition.
- serialOut is registered and glitch-free.
- Frame length in cycles = DIV·(1 + nbits + parityEn + nstop).

Decomposition:
- uart_pkg holds:
  - state encodings;
  - parity-mode codes PAR_NONE/PAR_EVEN/PAR_ODD;
  - baud select codes BAUD_1200..BAUD_9600;
  - dataBits-to-count mapping.
- One sub-module, uart_tx_fifo: synchronous FIFO with push/pop/full/empty/count, parameterised width 8 and depth FIFO_DEPTH, same clock and reset.

Test Plan (bench overrides DIV_1200..DIV_9600 = 16,8,6,4):
- 8N1, baud 3, push 0xA5 → line 0,1,0,1,0,0,1,0,1,1, each level 4 cycles; txDone pulses once; frame 40 cycles.
- 7E2, baud 1, push 0x83 → data 1,1,0,0,0,0,0; parity 0; two stop periods; frame 88 cycles; bit 7 never sent.
- 5O1, baud 0, push 0x1F → data 1,1,1,1,1; parity 0; frame 128 cycles.
- Burst: push 5 words while idle, DEPTH 4 → inReady drops after the FIFO fills; no idle-high gap longer than the stop period between frames; all 5 words are serialised in order with 5 txDone pulses.
- Change baudRate and dataBits mid-frame → current frame is unaffected; the next popped frame uses the new values.
- Reset asserted during DATA bit 3 → next cycle serialOut=1, busy=0, fifoCount=0; inReady=1 after release; a fresh push transmits correctly.
